// File: rtl/oflow_id_assign_pkg.sv
// Shared types, widths and defaults for the final-ID assignment stage.
package oflow_id_assign_pkg;

    localparam int MAX_ROWS  = 8;
    localparam int PE_NUM    = 8;
    localparam int ROW_LEN   = 3;
    localparam int PE_LEN    = 3;
    localparam int SCORE_LEN = 16;
    localparam int ID_LEN    = 12;

    localparam logic [SCORE_LEN-1:0] SCORE_TH_DEF = 16'h0400;
    localparam int                   ID_MAX_DEF   = 4095;

    typedef enum logic [1:0] {
        ida_idle_st,
        ida_rd_st,
        ida_emit_st,
        ida_done_st
    } ida_state_t;

    // Width able to hold any bbox count 0..rows*pes.
    function automatic int bbox_idx_w(input int rows, input int pes);
        return $clog2(rows * pes + 1);
    endfunction

    localparam int NBOX_W = bbox_idx_w(MAX_ROWS, PE_NUM);

endpackage

// File: rtl/oflow_id_assign_fsm_if.sv
// Score-board read port plus result stream of the ID-assignment stage.
interface oflow_id_assign_fsm_if;
    import oflow_id_assign_pkg::*;

    logic [ROW_LEN-1:0]   row_sel;
    logic [PE_LEN-1:0]    pe_sel;
    logic [SCORE_LEN-1:0] score_in;
    logic [ID_LEN-1:0]    id_in;
    logic                 winner_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [NBOX_W-1:0]    out_bbox_idx;
    logic [ID_LEN-1:0]    out_id;
    logic                 out_new_flg;

    modport master (
        output row_sel, pe_sel, out_valid, out_bbox_idx, out_id, out_new_flg,
        input  score_in, id_in, winner_in, out_ready
    );

    modport slave (
        input  row_sel, pe_sel, out_valid, out_bbox_idx, out_id, out_new_flg,
        output score_in, id_in, winner_in, out_ready
    );

endinterface

// File: rtl/oflow_new_id_allocator.sv
// Persistent fresh-ID counter; skips the reserved ID 0 when it wraps.
module oflow_new_id_allocator #(
    parameter int ID_W   = 12,
    parameter int ID_MAX = 4095
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_en,
    output logic [ID_W-1:0] next_id
);

    localparam logic [ID_W-1:0] ID_LAST = ID_W'(ID_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            next_id <= ID_W'(1);
        end else if (alloc_en) begin
            next_id <= (next_id == ID_LAST) ? ID_W'(1) : next_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/oflow_id_assign_fsm.sv
// Walks the score board in bbox order and streams one final ID per bbox.
// state | meaning: IDLE wait start | RD read board, decide | EMIT hold result until ready | DONE end pulse
module oflow_id_assign_fsm
    import oflow_id_assign_pkg::*;
#(
    parameter int                   ROWS     = MAX_ROWS,
    parameter int                   PES      = PE_NUM,
    parameter logic [SCORE_LEN-1:0] SCORE_TH = SCORE_TH_DEF,
    parameter int                   ID_MAX   = ID_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset_N,
    input  logic                   start_ida,
    input  logic                   first_frame,
    input  logic [NBOX_W-1:0]      num_of_bbox,
    output logic                   done_ida,
    output logic                   busy,
    oflow_id_assign_fsm_if.master  sb
);

    localparam logic [NBOX_W-1:0] BBOX_CAP = NBOX_W'(ROWS * PES);
    localparam logic [PE_LEN-1:0] PE_LAST  = PE_LEN'(PES - 1);

    ida_state_t          state, state_nxt;
    logic [NBOX_W-1:0]   num_l;
    logic                ff_l;
    logic [ROW_LEN-1:0]  row_cnt;
    logic [PE_LEN-1:0]   pe_cnt;
    logic [NBOX_W-1:0]   idx_cnt;
    logic [ID_LEN-1:0]   out_id_r;
    logic                out_new_r;
    logic [NBOX_W-1:0]   out_idx_r;

    logic [NBOX_W-1:0]   num_clamped;
    logic                keep;
    logic                alloc_en;
    logic                last_bbox;
    logic [ID_LEN-1:0]   next_id;

    oflow_new_id_allocator #(
        .ID_W   (ID_LEN),
        .ID_MAX (ID_MAX)
    ) u_alloc (
        .clk      (clk),
        .reset    (reset_N),
        .alloc_en (alloc_en),
        .next_id  (next_id)
    );

    always_comb begin
        num_clamped = (num_of_bbox > BBOX_CAP) ? BBOX_CAP : num_of_bbox;
        keep        = !ff_l && sb.winner_in && (sb.score_in <= SCORE_TH) && (sb.id_in != '0);
        alloc_en    = (state == ida_rd_st) && !keep;
        last_bbox   = (idx_cnt + NBOX_W'(1)) == num_l;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ida_idle_st: begin
                if (start_ida) begin
                    state_nxt = (num_clamped == '0) ? ida_done_st : ida_rd_st;
                end
            end
            ida_rd_st: state_nxt = ida_emit_st;
            ida_emit_st: begin
                if (sb.out_ready) begin
                    state_nxt = last_bbox ? ida_done_st : ida_rd_st;
                end
            end
            ida_done_st: state_nxt = ida_idle_st;
            default: state_nxt = ida_idle_st;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_N) begin
            state     <= ida_idle_st;
            num_l     <= '0;
            ff_l      <= 1'b0;
            row_cnt   <= '0;
            pe_cnt    <= '0;
            idx_cnt   <= '0;
            out_id_r  <= '0;
            out_new_r <= 1'b0;
            out_idx_r <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ida_idle_st: begin
                    if (start_ida) begin
                        num_l   <= num_clamped;
                        ff_l    <= first_frame;
                        row_cnt <= '0;
                        pe_cnt  <= '0;
                        idx_cnt <= '0;
                    end
                end
                ida_rd_st: begin
                    out_idx_r <= idx_cnt;
                    if (keep) begin
                        out_id_r  <= sb.id_in;
                        out_new_r <= 1'b0;
                    end else begin
                        out_id_r  <= next_id;
                        out_new_r <= 1'b1;
                    end
                end
                ida_emit_st: begin
                    // Counters move only on an accepted result, so a stall freezes the walk.
                    if (sb.out_ready) begin
                        idx_cnt <= idx_cnt + NBOX_W'(1);
                        if (pe_cnt == PE_LAST) begin
                            pe_cnt  <= '0;
                            row_cnt <= row_cnt + ROW_LEN'(1);
                        end else begin
                            pe_cnt <= pe_cnt + PE_LEN'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sb.row_sel      = (state == ida_rd_st) ? row_cnt : '0;
        sb.pe_sel       = (state == ida_rd_st) ? pe_cnt  : '0;
        sb.out_valid    = (state == ida_emit_st);
        sb.out_bbox_idx = out_idx_r;
        sb.out_id       = out_id_r;
        sb.out_new_flg  = out_new_r;
        done_ida        = (state == ida_done_st);
        busy            = (state != ida_idle_st);
    end

endmodule

// File: tb/tb_oflow_id_assign_fsm.sv
// Directed scenarios for the final-ID assignment stage with a behavioural score board.
module tb_oflow_id_assign_fsm;
    import oflow_id_assign_pkg::*;

    logic        clk = 1'b0;
    logic        reset_N;
    logic        start_ida;
    logic        first_frame;
    logic [6:0]  num_of_bbox;
    logic        done_ida;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_score [64];
    logic [11:0] sb_id    [64];
    logic        sb_win   [64];

    oflow_id_assign_fsm_if sbif ();

    oflow_id_assign_fsm dut (
        .clk         (clk),
        .reset_N     (reset_N),
        .start_ida   (start_ida),
        .first_frame (first_frame),
        .num_of_bbox (num_of_bbox),
        .done_ida    (done_ida),
        .busy        (busy),
        .sb          (sbif.master)
    );

    always #5 clk = ~clk;

    // PES is 8, so {row,pe} is exactly row*8+pe.
    assign sbif.score_in  = sb_score[{sbif.row_sel, sbif.pe_sel}];
    assign sbif.id_in     = sb_id[{sbif.row_sel, sbif.pe_sel}];
    assign sbif.winner_in = sb_win[{sbif.row_sel, sbif.pe_sel}];

    task automatic clear_board();
        for (int k = 0; k < 64; k++) begin
            sb_score[k] = 16'h0;
            sb_id[k]    = 12'h0;
            sb_win[k]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_N = 1'b1;
        repeat (2) @(negedge clk);
        reset_N = 1'b0;
    endtask

    // Leaves the caller at the negedge right after the start edge.
    task automatic start_frame(input logic ff, input logic [6:0] n);
        @(negedge clk);
        start_ida   = 1'b1;
        first_frame = ff;
        num_of_bbox = n;
        @(negedge clk);
        start_ida   = 1'b0;
    endtask

    // Captures the next valid result; id is X on timeout so the caller's compare fails.
    task automatic get_out(output logic [11:0] id, output logic nw, output logic [6:0] idx);
        id  = 12'hxxx;
        nw  = 1'bx;
        idx = 7'hxx;
        for (int c = 0; c < 20; c++) begin
            if (sbif.out_valid) begin
                id  = sbif.out_id;
                nw  = sbif.out_new_flg;
                idx = sbif.out_bbox_idx;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_bulk(input logic [6:0] n, output int cnt, output logic [6:0] last_idx);
        start_frame(1'b1, n);
        cnt      = 0;
        last_idx = '0;
        for (int c = 0; c < 400; c++) begin
            if (sbif.out_valid) begin
                cnt++;
                last_idx = sbif.out_bbox_idx;
            end
            if (done_ida) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        do_reset();
        @(negedge clk);
        checks++;
        if (sbif.out_valid !== 1'b0 || busy !== 1'b0 || done_ida !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b required 0 0 0", sbif.out_valid, busy, done_ida);
        end
        checks++;
        if (sbif.out_id !== 12'd0 || sbif.out_bbox_idx !== 7'd0 || sbif.out_new_flg !== 1'b0 ||
            sbif.row_sel !== 3'd0 || sbif.pe_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: id=%0d idx=%0d new=%b row=%0d pe=%0d required all 0",
                     sbif.out_id, sbif.out_bbox_idx, sbif.out_new_flg, sbif.row_sel, sbif.pe_sel);
        end
    endtask

    task automatic test_first_frame();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        start_frame(1'b1, 7'd3);
        checks++;
        if (sbif.out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_rd: valid=%b busy=%b required 0 1", sbif.out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (sbif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_emit: valid=%b required 1", sbif.out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            get_out(id, nw, idx);
            checks++;
            if (id !== 12'(k + 1) || nw !== 1'b1 || idx !== 7'(k)) begin
                errors++;
                $display("FAIL first_frame_out%0d: id=%0d new=%b idx=%0d required %0d 1 %0d", k, id, nw, idx, k + 1, k);
            end
        end
        checks++;
        if (done_ida !== 1'b1 || sbif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b valid=%b required 1 0", done_ida, sbif.out_valid);
        end
        @(negedge clk);
        checks++;
        if (done_ida !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b busy=%b required 0 0", done_ida, busy);
        end
    endtask

    task automatic test_keep_vs_new();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        clear_board();
        sb_win[0] = 1'b1; sb_score[0] = 16'h0100; sb_id[0] = 12'd7;
        sb_win[1] = 1'b0; sb_score[1] = 16'h0100; sb_id[1] = 12'd7;
        start_frame(1'b0, 7'd2);
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd7 || nw !== 1'b0 || idx !== 7'd0) begin
            errors++;
            $display("FAIL keep_winner: id=%0d new=%b idx=%0d required 7 0 0", id, nw, idx);
        end
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd4 || nw !== 1'b1 || idx !== 7'd1) begin
            errors++;
            $display("FAIL loser_new: id=%0d new=%b idx=%0d required 4 1 1", id, nw, idx);
        end
        @(negedge clk);
    endtask

    task automatic test_threshold();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        clear_board();
        sb_win[0] = 1'b1; sb_score[0] = 16'h0401; sb_id[0] = 12'd9;
        sb_win[1] = 1'b1; sb_score[1] = 16'h0400; sb_id[1] = 12'd9;
        sb_win[2] = 1'b1; sb_score[2] = 16'h0000; sb_id[2] = 12'd0;
        start_frame(1'b0, 7'd3);
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd5 || nw !== 1'b1) begin
            errors++;
            $display("FAIL score_above_th: id=%0d new=%b required 5 1", id, nw);
        end
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd9 || nw !== 1'b0) begin
            errors++;
            $display("FAIL score_at_th: id=%0d new=%b required 9 0", id, nw);
        end
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd6 || nw !== 1'b1 || idx !== 7'd2) begin
            errors++;
            $display("FAIL zero_id: id=%0d new=%b idx=%0d required 6 1 2", id, nw, idx);
        end
        @(negedge clk);
    endtask

    task automatic test_row_wrap();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        clear_board();
        for (int k = 0; k < 10; k++) begin
            sb_win[k] = 1'b1;
            sb_id[k]  = 12'(100 + k);
        end
        start_frame(1'b0, 7'd10);
        for (int k = 0; k < 10; k++) begin
            get_out(id, nw, idx);
            checks++;
            if (id !== 12'(100 + k) || nw !== 1'b0 || idx !== 7'(k)) begin
                errors++;
                $display("FAIL walk_order%0d: id=%0d new=%b idx=%0d required %0d 0 %0d", k, id, nw, idx, 100 + k, k);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        sbif.out_ready = 1'b0;
        start_frame(1'b1, 7'd2);
        @(negedge clk);
        checks++;
        if (sbif.out_valid !== 1'b1 || sbif.out_id !== 12'd7 || sbif.out_bbox_idx !== 7'd0) begin
            errors++;
            $display("FAIL stall_first: valid=%b id=%0d idx=%0d required 1 7 0", sbif.out_valid, sbif.out_id, sbif.out_bbox_idx);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (sbif.out_valid !== 1'b1 || sbif.out_id !== 12'd7 || sbif.out_bbox_idx !== 7'd0 || sbif.out_new_flg !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b id=%0d idx=%0d new=%b required 1 7 0 1",
                         c, sbif.out_valid, sbif.out_id, sbif.out_bbox_idx, sbif.out_new_flg);
            end
        end
        sbif.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (sbif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b required 0", sbif.out_valid);
        end
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd8 || idx !== 7'd1) begin
            errors++;
            $display("FAIL after_stall: id=%0d idx=%0d required 8 1", id, idx);
        end
        @(negedge clk);
    endtask

    task automatic test_alloc_wrap();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        int cnt;
        int remaining;
        logic [6:0] last_idx;
        run_bulk(7'd100, cnt, last_idx);
        checks++;
        if (cnt != 64 || last_idx !== 7'd63) begin
            errors++;
            $display("FAIL clamp: count=%0d last_idx=%0d required 64 63", cnt, last_idx);
        end
        remaining = 4095 - 9 - 64;
        while (remaining > 0) begin
            run_bulk((remaining >= 64) ? 7'd64 : 7'(remaining), cnt, last_idx);
            remaining -= (remaining >= 64) ? 64 : remaining;
        end
        start_frame(1'b1, 7'd2);
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd4095 || nw !== 1'b1) begin
            errors++;
            $display("FAIL id_max: id=%0d new=%b required 4095 1", id, nw);
        end
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd1 || nw !== 1'b1) begin
            errors++;
            $display("FAIL id_wrap: id=%0d new=%b required 1 1", id, nw);
        end
        @(negedge clk);
        start_frame(1'b1, 7'd0);
        checks++;
        if (done_ida !== 1'b1 || sbif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_frame: done=%b valid=%b required 1 0", done_ida, sbif.out_valid);
        end
        @(negedge clk);
        checks++;
        if (done_ida !== 1'b0 || busy !== 1'b0 || sbif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_frame_end: done=%b busy=%b valid=%b required 0 0 0", done_ida, busy, sbif.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] id;
        logic nw;
        logic [6:0] idx;
        bit seen;
        start_frame(1'b1, 7'd5);
        get_out(id, nw, idx);
        get_out(id, nw, idx);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (sbif.out_valid && sbif.out_bbox_idx == 7'd2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_bbox2: timeout waiting for bbox 2, idx=%0d required 2", sbif.out_bbox_idx);
        end
        reset_N = 1'b1;
        @(negedge clk);
        reset_N = 1'b0;
        checks++;
        if (sbif.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b required 0 0", sbif.out_valid, busy);
        end
        start_frame(1'b1, 7'd2);
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd1 || nw !== 1'b1 || idx !== 7'd0) begin
            errors++;
            $display("FAIL restart_id: id=%0d new=%b idx=%0d required 1 1 0", id, nw, idx);
        end
        start_ida   = 1'b1;
        first_frame = 1'b0;
        num_of_bbox = 7'd0;
        get_out(id, nw, idx);
        checks++;
        if (id !== 12'd2 || nw !== 1'b1 || idx !== 7'd1) begin
            errors++;
            $display("FAIL start_while_busy: id=%0d new=%b idx=%0d required 2 1 1", id, nw, idx);
        end
        checks++;
        if (done_ida !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: done=%b required 1", done_ida);
        end
        @(negedge clk);
        start_ida = 1'b0;
        checks++;
        if (busy !== 1'b0 || done_ida !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b done=%b required 0 0", busy, done_ida);
        end
    endtask

    initial begin
        reset_N        = 1'b1;
        start_ida      = 1'b0;
        first_frame    = 1'b0;
        num_of_bbox    = 7'd0;
        sbif.out_ready = 1'b1;
        clear_board();

        test_reset();
        test_first_frame();
        test_keep_vs_new();
        test_threshold();
        test_row_wrap();
        test_back_pressure();
        test_alloc_wrap();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
